// File: rtl/lc3b_types.sv
// Shared LC-3b load/store op encoding, op classification and AGU entry type.
// Imported by agu_issue_queue and its testbench.
package lc3b_types;

    typedef enum logic [3:0] {
        LSQ_LDB = 4'b0010,
        LSQ_STB = 4'b0011,
        LSQ_LDR = 4'b0110,
        LSQ_STR = 4'b0111,
        LSQ_LDI = 4'b1010,
        LSQ_STI = 4'b1011
    } lc3b_lsq_op;

    // Per-station control state; operand values and tags live
    // in parameter-width arrays beside it.
    typedef struct packed {
        logic       rdy;
        logic       pj;
        logic       pk;
        lc3b_lsq_op op;
    } agu_entry_t;

    // Word ops scale the offset by two; byte ops use it as-is.
    function automatic logic is_word_op(input lc3b_lsq_op op);
        case (op)
            LSQ_LDR, LSQ_STR, LSQ_LDI, LSQ_STI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/agu_pipe.sv
// Address pipeline: stage 1 adds base + (scaled) offset, later stages delay.
// Ports: in_* issue side (valid/ready), out_* result side (valid/ready), flush.
module agu_pipe #(
    parameter int AGU_LATENCY = 2,
    parameter int WORD_W      = 16,
    parameter int TAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_word,
    input  logic [WORD_W-1:0] in_base,
    input  logic [WORD_W-1:0] in_off,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_dest,
    output logic [WORD_W-1:0] out_addr
);

    logic [AGU_LATENCY-1:0] v_q;
    logic [AGU_LATENCY-1:0] take;
    logic [WORD_W-1:0]      a_q [AGU_LATENCY];
    logic [TAG_W-1:0]       d_q [AGU_LATENCY];
    logic [WORD_W-1:0]      sum;

    // A stage accepts when empty or when its content moves on, so
    // bubbles collapse even while the last stage is stalled.
    always_comb begin
        take = '0;
        take[AGU_LATENCY-1] = !v_q[AGU_LATENCY-1] || out_ready;
        for (int i = AGU_LATENCY - 2; i >= 0; i--) begin
            take[i] = !v_q[i] || take[i+1];
        end
    end

    assign sum = in_base + (in_word ? {in_off[WORD_W-2:0], 1'b0} : in_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < AGU_LATENCY; i++) begin
                a_q[i] <= '0;
                d_q[i] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            if (take[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    a_q[0] <= sum;
                    d_q[0] <= in_dest;
                end
            end
            for (int i = 1; i < AGU_LATENCY; i++) begin
                if (take[i]) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        a_q[i] <= a_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = take[0];
    assign out_valid = v_q[AGU_LATENCY-1];
    assign out_addr  = a_q[AGU_LATENCY-1];
    assign out_dest  = d_q[AGU_LATENCY-1];

endmodule

// File: rtl/agu_issue_queue.sv
// AGU reservation stations: CDB snoop, oldest-ready issue, address pipeline.
// Ports: alloc_* dispatch, cdb_* snoop, out_* result, free_count, flush.
module agu_issue_queue
    import lc3b_types::*;
#(
    parameter int NUM_STATIONS = 4,
    parameter int AGU_LATENCY  = 2,
    parameter int ROB_ID_W     = 4,
    parameter int WORD_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [3:0]                        alloc_op,
    input  logic [WORD_W-1:0]                 alloc_vj,
    input  logic [WORD_W-1:0]                 alloc_vk,
    input  logic [ROB_ID_W-1:0]               alloc_qj,
    input  logic [ROB_ID_W-1:0]               alloc_qk,
    input  logic                              alloc_qj_pend,
    input  logic                              alloc_qk_pend,
    input  logic [ROB_ID_W-1:0]               alloc_dest,
    input  logic                              cdb_valid,
    input  logic [ROB_ID_W-1:0]               cdb_tag,
    input  logic [WORD_W-1:0]                 cdb_value,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ROB_ID_W-1:0]               out_dest,
    output logic [WORD_W-1:0]                 out_addr,
    output logic [$clog2(NUM_STATIONS+1)-1:0] free_count,
    input  logic                              flush
);

    localparam int CNT_W = $clog2(NUM_STATIONS + 1);
    localparam int IDX_W = $clog2(NUM_STATIONS);

    logic [NUM_STATIONS-1:0] valid_q;
    logic [NUM_STATIONS-1:0] valid_n;
    logic [NUM_STATIONS-1:0] alloc_sel;
    logic [NUM_STATIONS-1:0] cand;
    logic [NUM_STATIONS-1:0] iss_sel;
    agu_entry_t              ent_q  [NUM_STATIONS];
    logic [WORD_W-1:0]       vj_q   [NUM_STATIONS];
    logic [WORD_W-1:0]       vk_q   [NUM_STATIONS];
    logic [ROB_ID_W-1:0]     qj_q   [NUM_STATIONS];
    logic [ROB_ID_W-1:0]     qk_q   [NUM_STATIONS];
    logic [ROB_ID_W-1:0]     dest_q [NUM_STATIONS];
    // age_q[i][j] set: entry i was allocated before entry j
    logic [NUM_STATIONS-1:0] age_q  [NUM_STATIONS];
    logic [NUM_STATIONS-1:0] older  [NUM_STATIONS];
    logic [CNT_W-1:0]        free_q;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        iss_idx;
    logic                    alloc_fire;
    logic                    issue_fire;
    logic                    pipe_ready;
    logic                    bj_hit;
    logic                    bk_hit;

    assign alloc_ready = (free_q != '0) && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    // isolate the lowest clear bit of valid_q
    assign alloc_sel   = ~valid_q & (valid_q + 1'b1);

    assign bj_hit = cdb_valid && alloc_qj_pend && (cdb_tag == alloc_qj);
    assign bk_hit = cdb_valid && alloc_qk_pend && (cdb_tag == alloc_qk);

    always_comb begin
        cand    = '0;
        iss_sel = '0;
        iss_idx = '0;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            cand[i] = valid_q[i] && ent_q[i].rdy;
            for (int j = 0; j < NUM_STATIONS; j++) begin
                older[i][j] = age_q[j][i];
            end
        end
        for (int i = 0; i < NUM_STATIONS; i++) begin
            iss_sel[i] = cand[i] && ((cand & older[i]) == '0);
            if (iss_sel[i]) begin
                iss_idx = IDX_W'(i);
            end
        end
    end

    assign issue_fire = (cand != '0) && pipe_ready && !flush;

    always_comb begin
        valid_n = valid_q;
        if (issue_fire) begin
            valid_n = valid_n & ~iss_sel;
        end
        if (alloc_fire) begin
            valid_n = valid_n | alloc_sel;
        end
        if (flush) begin
            valid_n = '0;
        end
        cnt = '0;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            cnt = cnt + CNT_W'(valid_n[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            free_q  <= CNT_W'(NUM_STATIONS);
            for (int i = 0; i < NUM_STATIONS; i++) begin
                ent_q[i]  <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_n;
            free_q  <= CNT_W'(NUM_STATIONS) - cnt;
            for (int i = 0; i < NUM_STATIONS; i++) begin
                if (flush) begin
                    ent_q[i].rdy <= 1'b0;
                    age_q[i]     <= '0;
                end else if (alloc_fire && alloc_sel[i]) begin
                    ent_q[i].op  <= lc3b_lsq_op'(alloc_op);
                    ent_q[i].rdy <= 1'b0;
                    ent_q[i].pj  <= alloc_qj_pend && !bj_hit;
                    ent_q[i].pk  <= alloc_qk_pend && !bk_hit;
                    vj_q[i]      <= bj_hit ? cdb_value : alloc_vj;
                    vk_q[i]      <= bk_hit ? cdb_value : alloc_vk;
                    qj_q[i]      <= alloc_qj;
                    qk_q[i]      <= alloc_qk;
                    dest_q[i]    <= alloc_dest;
                    age_q[i]     <= '0;
                end else begin
                    // ready lags the last capture by one cycle
                    ent_q[i].rdy <= valid_n[i] && valid_q[i] &&
                                    !ent_q[i].pj && !ent_q[i].pk;
                    if (alloc_fire) begin
                        age_q[i] <= age_q[i] | alloc_sel;
                    end
                    if (valid_q[i] && cdb_valid) begin
                        if (ent_q[i].pj && (qj_q[i] == cdb_tag)) begin
                            vj_q[i]     <= cdb_value;
                            ent_q[i].pj <= 1'b0;
                        end
                        if (ent_q[i].pk && (qk_q[i] == cdb_tag)) begin
                            vk_q[i]     <= cdb_value;
                            ent_q[i].pk <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign free_count = free_q;

    agu_pipe #(
        .AGU_LATENCY (AGU_LATENCY),
        .WORD_W      (WORD_W),
        .TAG_W       (ROB_ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (issue_fire),
        .in_ready  (pipe_ready),
        .in_word   (is_word_op(ent_q[iss_idx].op)),
        .in_base   (vj_q[iss_idx]),
        .in_off    (vk_q[iss_idx]),
        .in_dest   (dest_q[iss_idx]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dest  (out_dest),
        .out_addr  (out_addr)
    );

endmodule

// File: doc/agu_issue_queue.md
AGU_ISSUE_QUEUE -- requirements
Module: agu_issue_queue

Interface
REQ-001 Parameter NUM_STATIONS, default 4, number of AGU reservation entries (2..16).
REQ-002 Parameter AGU_LATENCY, default 2, address pipeline depth in cycles (1..4).
REQ-003 Parameter ROB_ID_W, default 4, ROB tag width.
REQ-004 Parameter WORD_W, default 16, data/address width.
REQ-005 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 alloc_valid  input  1  dispatch offers an AGU op.
REQ-009 alloc_ready  output  1  at least one free entry and no flush.
REQ-010 alloc_op  input  4  lc3b_lsq_op encoding.
REQ-011 alloc_vj, alloc_vk  input  WORD_W each  base, offset values.
REQ-012 alloc_qj, alloc_qk  input  ROB_ID_W each  producer tags.
REQ-013 alloc_qj_pend, alloc_qk_pend  input  1 each  operand still pending on tag.
REQ-014 alloc_dest  input  ROB_ID_W  destination ROB tag.
REQ-015 cdb_valid, cdb_tag, cdb_value  input  1/ROB_ID_W/WORD_W  result broadcast snoop.
REQ-016 out_valid  output  1  computed address available.
REQ-017 out_ready  input  1  CDB arbiter accepts result.
REQ-018 out_dest, out_addr  output  ROB_ID_W/WORD_W  result tag and address.
REQ-019 free_count  output  $clog2(NUM_STATIONS+1)  number of free entries.
REQ-020 flush  input  1  squash all entries and in-flight ops.

Function
REQ-021 Allocation fires when alloc_valid && alloc_ready; op is written into lowest-index free entry at that clock edge.
REQ-022 An operand whose pending tag equals cdb_tag with cdb_valid in the allocation cycle SHALL be captured as ready with cdb_value (same-cycle bypass).
REQ-023 Each valid entry with a pending operand SHALL capture cdb_value and clear pending when cdb_valid and tag match; both operands may capture in one cycle.
REQ-024 An entry is ready when valid and neither operand pending; it becomes issue-eligible the cycle after its last capture.
REQ-025 Issue selects the oldest ready entry by allocation order (age matrix), at most one per cycle; entry is freed at the issue edge.
REQ-026 Pipeline stage 1 computes address = vj + (word op ? vk<<1 : vk), modulo 2^WORD_W; remaining stages are delay registers.
REQ-027 out_valid/out_dest/out_addr SHALL reflect the last pipeline stage; total issue-to-out_valid latency is AGU_LATENCY cycles.
REQ-028 Result transfers when out_valid && out_ready; while out_valid && !out_ready, all stages hold, outputs remain stable, and issue stalls if stage 1 is occupied.
REQ-029 Empty pipeline bubbles SHALL collapse under stall (a stage advances if its successor is empty or advancing).
REQ-030 Full queue: alloc_ready=0; an allocation and an issue in the same cycle on a full queue is not permitted (alloc_ready does not look ahead).
REQ-031 Empty queue with no ready entry: no issue, pipeline drains normally.
REQ-032 flush SHALL invalidate all entries and pipeline stages at the next edge; alloc and issue in that cycle are ignored; out_valid is 0 the following cycle.
REQ-033 free_count SHALL equal NUM_STATIONS minus valid entries, registered.

Reset
REQ-034 rst_n low SHALL immediately clear all entry valid bits, age matrix and pipeline valid bits.
REQ-035 During and after reset: out_valid=0, alloc_ready=1, free_count=NUM_STATIONS, out_dest=0, out_addr=0.
REQ-036 Reset asserted mid-operation SHALL discard all queued and in-flight ops; no output is produced for them.

Structure
REQ-037 lc3b_lsq_op encoding, word/byte classification function, and entry struct type SHALL live in lc3b_types.
REQ-038 Address arithmetic and delay stages SHALL be one sub-module, agu_pipe, parametrised by AGU_LATENCY and WORD_W.

Verification
REQ-039 Alloc op LDR vj=0x1000 vk=0x0004 no pending, out_ready=1, AGU_LATENCY=2 -> out_valid 3 cycles after alloc edge, out_addr=0x1008.
REQ-040 Alloc LDB vj pending tag 5, vk=0x0003; cdb tag 5 value 0x2000 two cycles later -> out_addr=0x2003, not before capture+1+AGU_LATENCY.
REQ-041 Fill 4 entries with alloc_valid held -> alloc_ready=0, free_count=0; one issue -> alloc_ready=1 next cycle.
REQ-042 Two ready entries allocated in order A then B into slots 2 and 0 -> A issues first.
REQ-043 out_ready=0 for 5 cycles with results pending -> out_addr/out_dest stable, no result lost or duplicated after release.
REQ-044 flush with 3 queued and 2 in flight -> out_valid=0 next cycle, free_count=NUM_STATIONS; vj=0xFFFF vk=0x0001 STB after -> out_addr=0x0000.
